otter_io_timer: RTL and testbench

Memory-mapped timer/compare peripheral on the OTTER MCU I/O bus, downstream of the MCU's `IOBUS_OUT`/`IOBUS_ADDR`/`IOBUS_WR` outputs. It decodes its own register window, returns read data for the `IOBUS_IN` return mux, and raises a level interrupt intended for the MCU's `INTR` input. It provides a prescaled 32-bit up-counter with compare, one-shot and periodic modes, and a write-1-to-clear status flag.

---
 rtl/otter_timer_pkg.sv | 22 ++
 rtl/otter_prescaler.sv | 26 ++
 rtl/otter_io_timer.sv | 110 +++++++++++
 tb/tb_otter_io_timer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_timer_pkg.sv
// Shared constants and types for the OTTER I/O timer peripheral.
package otter_timer_pkg;

   // Byte offsets of the registers inside the 32-byte window.
   localparam logic [4:0] TMR_CTRL     = 5'h00;
   localparam logic [4:0] TMR_PRESCALE = 5'h04;
   localparam logic [4:0] TMR_COMPARE  = 5'h08;
   localparam logic [4:0] TMR_COUNT    = 5'h0C;
   localparam logic [4:0] TMR_STATUS   = 5'h10;

   // CTRL bit positions.
   localparam int CTRL_EN  = 0;
   localparam int CTRL_PER = 1;
   localparam int CTRL_IE  = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } tmr_state_t;

endpackage

// File: rtl/otter_prescaler.sv
// Prescale counter: ticks once every (limit+1) enabled cycles.
module otter_prescaler (
   input  logic        CLK,
   input  logic        RST,
   input  logic        en,
   input  logic        clr,
   input  logic [31:0] limit,
   output logic        tick
);

   logic [31:0] pcnt;

   // A tick is the enabled cycle in which pcnt has reached the limit.
   assign tick = en && (pcnt == limit);

   // Free-run while enabled, wrap to 0 on each tick; clear has priority.
   always_ff @(posedge CLK) begin
      if (RST)
         pcnt <= '0;
      else if (clr)
         pcnt <= '0;
      else if (en)
         pcnt <= tick ? 32'd0 : pcnt + 32'd1;
   end

endmodule

// File: rtl/otter_io_timer.sv
// Memory-mapped timer/compare peripheral for the OTTER I/O bus.
module otter_io_timer
   import otter_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1100_0300
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] RD_DATA,
   output logic        HIT,
   output logic        INTR
);

   tmr_state_t  state;
   logic        periodic, ie, match;
   logic [31:0] prescale, compare, count;
   logic        tick, eff_tick, match_set;
   logic        wr, ctrl_wr, pre_wr, cmp_wr, cnt_wr, stat_wr;
   logic [31:0] off;
   logic [2:0]  word;
   logic        addr_lsb_unused;

   // Offset relative to the base; an address below the base wraps high and misses.
   assign off  = IOBUS_ADDR - BASE_ADDR;
   assign HIT  = (off[31:5] == 27'd0);
   assign word = off[4:2];
   // Byte lane bits are intentionally ignored by the decode.
   assign addr_lsb_unused = ^off[1:0];

   assign wr      = IOBUS_WR && HIT;
   assign ctrl_wr = wr && (word == TMR_CTRL[4:2]);
   assign pre_wr  = wr && (word == TMR_PRESCALE[4:2]);
   assign cmp_wr  = wr && (word == TMR_COMPARE[4:2]);
   assign cnt_wr  = wr && (word == TMR_COUNT[4:2]);
   assign stat_wr = wr && (word == TMR_STATUS[4:2]);

   otter_prescaler u_prescaler (
      .CLK   (CLK),
      .RST   (RST),
      .en    (state == RUN),
      .clr   ((ctrl_wr && IOBUS_OUT[CTRL_EN]) || cnt_wr),
      .limit (prescale),
      .tick  (tick)
   );

   // A COUNT write in the tick cycle discards the tick entirely.
   assign eff_tick  = tick && !cnt_wr;
   assign match_set = eff_tick && (count == compare);

   assign INTR = match && ie;

   // Combinational read mux; en reflects the FSM so it drops on one-shot expiry.
   always_comb begin
      RD_DATA = '0;
      if (HIT) begin
         case (word)
            TMR_CTRL[4:2]:     RD_DATA = {29'd0, ie, periodic, state == RUN};
            TMR_PRESCALE[4:2]: RD_DATA = prescale;
            TMR_COMPARE[4:2]:  RD_DATA = compare;
            TMR_COUNT[4:2]:    RD_DATA = count;
            TMR_STATUS[4:2]:   RD_DATA = {31'd0, match};
            default:           RD_DATA = '0;
         endcase
      end
   end

   // Register file, FSM and compare logic.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         periodic <= 1'b0;
         ie       <= 1'b0;
         prescale <= '0;
         compare  <= '0;
         count    <= '0;
         match    <= 1'b0;
      end else begin
         if (pre_wr) prescale <= IOBUS_OUT;
         if (cmp_wr) compare  <= IOBUS_OUT;

         if (ctrl_wr) begin
            periodic <= IOBUS_OUT[CTRL_PER];
            ie       <= IOBUS_OUT[CTRL_IE];
         end

         // CTRL write beats a concurrent one-shot expiry.
         if (ctrl_wr)
            state <= IOBUS_OUT[CTRL_EN] ? RUN : IDLE;
         else if (match_set && !periodic)
            state <= EXPIRED;

         if (cnt_wr)
            count <= IOBUS_OUT;
         else if (match_set)
            count <= periodic ? 32'd0 : count;
         else if (eff_tick)
            count <= count + 32'd1;

         // Set beats a concurrent write-1-to-clear.
         if (match_set)
            match <= 1'b1;
         else if (stat_wr && IOBUS_OUT[0])
            match <= 1'b0;
      end
   end

endmodule

// File: tb/tb_otter_io_timer.sv
// Directed self-checking bench for otter_io_timer.
module tb_otter_io_timer;
   import otter_timer_pkg::*;

   localparam logic [31:0] BASE = 32'h1100_0300;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] IOBUS_ADDR = '0;
   logic [31:0] IOBUS_OUT = '0;
   logic        IOBUS_WR = 1'b0;
   logic [31:0] RD_DATA;
   logic        HIT;
   logic        INTR;

   int checks = 0;
   int failures = 0;

   otter_io_timer #(.BASE_ADDR(BASE)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .IOBUS_ADDR (IOBUS_ADDR),
      .IOBUS_OUT  (IOBUS_OUT),
      .IOBUS_WR   (IOBUS_WR),
      .RD_DATA    (RD_DATA),
      .HIT        (HIT),
      .INTR       (INTR)
   );

   always #5 CLK = ~CLK;

   // Called at a negedge; the write lands on the next rising edge, returns at the following negedge.
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      IOBUS_ADDR = addr;
      IOBUS_OUT  = data;
      IOBUS_WR   = 1'b1;
      @(negedge CLK);
      IOBUS_WR   = 1'b0;
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] d);
      IOBUS_ADDR = addr;
      #1;
      d = RD_DATA;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      IOBUS_WR = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         rd(BASE + 32'(i * 4), d);
         checks++;
         if (d !== 32'd0 || HIT !== 1'b1) begin
            failures++;
            $display("FAIL reset_read off=%0h rd=%h hit=%b want rd=0 hit=1", i * 4, d, HIT);
         end
      end
      checks++;
      if (INTR !== 1'b0) begin failures++; $display("FAIL reset_intr got %b want 0", INTR); end
      rd(BASE + 32'h20, d);
      checks++;
      if (HIT !== 1'b0 || d !== 32'd0) begin
         failures++; $display("FAIL window_top hit=%b rd=%h want hit=0 rd=0", HIT, d);
      end
      rd(BASE - 32'h4, d);
      checks++;
      if (HIT !== 1'b0 || d !== 32'd0) begin
         failures++; $display("FAIL window_below hit=%b rd=%h want hit=0 rd=0", HIT, d);
      end
   endtask

   task automatic test_periodic();
      logic [31:0] d, m;
      logic [31:0] seq [7];
      seq = '{0, 0, 1, 1, 2, 2, 0};
      do_reset();
      wr(BASE + TMR_PRESCALE, 32'd1);
      wr(BASE + TMR_COMPARE, 32'd2);
      wr(BASE + TMR_CTRL, 32'b111);              // enable edge E
      for (int k = 0; k < 7; k++) begin          // sampled after E+k
         rd(BASE + TMR_COUNT, d);
         rd(BASE + TMR_STATUS, m);
         checks++;
         if (d !== seq[k] || m !== ((k == 6) ? 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL periodic_seq k=%0d count=%0d match=%0d want count=%0d match=%0d",
                     k, d, m, seq[k], (k == 6) ? 1 : 0);
         end
         if (k < 6) @(negedge CLK);
      end
      checks++;
      if (INTR !== 1'b1) begin failures++; $display("FAIL periodic_intr got %b want 1", INTR); end
      wr(BASE + TMR_STATUS, 32'd1);              // W1C at E+7
      rd(BASE + TMR_STATUS, m);
      checks++;
      if (m !== 32'd0 || INTR !== 1'b0) begin
         failures++; $display("FAIL periodic_w1c match=%0d intr=%b want 0 0", m, INTR);
      end
      repeat (4) @(negedge CLK);                 // after E+11
      rd(BASE + TMR_STATUS, m);
      checks++;
      if (m !== 32'd0) begin failures++; $display("FAIL periodic_early match=%0d want 0", m); end
      @(negedge CLK);                            // after E+12
      rd(BASE + TMR_STATUS, m);
      checks++;
      if (m !== 32'd1 || INTR !== 1'b1) begin
         failures++; $display("FAIL periodic_rematch match=%0d intr=%b want 1 1", m, INTR);
      end
      // Collision: W1C landing on the match tick at E+18.
      repeat (5) @(negedge CLK);                 // after E+17
      wr(BASE + TMR_STATUS, 32'd1);              // edge E+18
      rd(BASE + TMR_STATUS, m);
      rd(BASE + TMR_COUNT, d);
      checks++;
      if (m !== 32'd1 || d !== 32'd0) begin
         failures++; $display("FAIL w1c_collide match=%0d count=%0d want 1 0", m, d);
      end
      // Collision: COUNT write landing on the tick at E+20.
      @(negedge CLK);                            // after E+19
      wr(BASE + TMR_COUNT, 32'h10);              // edge E+20
      rd(BASE + TMR_COUNT, d);
      checks++;
      if (d !== 32'h10) begin failures++; $display("FAIL count_collide got %h want 10", d); end
      @(negedge CLK);                            // E+21: pcnt restarted, no tick
      rd(BASE + TMR_COUNT, d);
      checks++;
      if (d !== 32'h10) begin failures++; $display("FAIL count_hold got %h want 10", d); end
      @(negedge CLK);                            // E+22: tick
      rd(BASE + TMR_COUNT, d);
      checks++;
      if (d !== 32'h11) begin failures++; $display("FAIL count_resume got %h want 11", d); end
   endtask

   task automatic test_oneshot();
      logic [31:0] d, m, c;
      do_reset();
      wr(BASE + TMR_PRESCALE, 32'd0);
      wr(BASE + TMR_COMPARE, 32'd3);
      wr(BASE + TMR_CTRL, 32'b101);              // edge E
      for (int k = 0; k < 7; k++) begin
         rd(BASE + TMR_COUNT, d);
         rd(BASE + TMR_STATUS, m);
         rd(BASE + TMR_CTRL, c);
         checks++;
         if (d !== ((k < 3) ? 32'(k) : 32'd3) || m !== ((k >= 4) ? 32'd1 : 32'd0) ||
             c !== ((k >= 4) ? 32'b100 : 32'b101)) begin
            failures++;
            $display("FAIL oneshot_seq k=%0d count=%0d match=%0d ctrl=%0h", k, d, m, c);
         end
         @(negedge CLK);
      end
      checks++;
      if (dut.state !== EXPIRED || INTR !== 1'b1) begin
         failures++; $display("FAIL oneshot_state state=%0d intr=%b want EXPIRED 1", dut.state, INTR);
      end
      wr(BASE + TMR_STATUS, 32'd1);
      wr(BASE + TMR_CTRL, 32'b101);              // re-enable at edge F
      rd(BASE + TMR_COUNT, d);
      rd(BASE + TMR_STATUS, m);
      rd(BASE + TMR_CTRL, c);
      checks++;
      if (d !== 32'd3 || m !== 32'd0 || c !== 32'b101) begin
         failures++; $display("FAIL oneshot_rearm count=%0d match=%0d ctrl=%0h want 3 0 5", d, m, c);
      end
      @(negedge CLK);                            // F+1: immediate match
      rd(BASE + TMR_COUNT, d);
      rd(BASE + TMR_STATUS, m);
      rd(BASE + TMR_CTRL, c);
      checks++;
      if (d !== 32'd3 || m !== 32'd1 || c !== 32'b100) begin
         failures++; $display("FAIL oneshot_rematch count=%0d match=%0d ctrl=%0h want 3 1 4", d, m, c);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] d, m;
      do_reset();
      wr(BASE + TMR_PRESCALE, 32'd0);
      wr(BASE + TMR_COMPARE, 32'd5);
      wr(BASE + TMR_COUNT, 32'hFFFF_FFFF);
      wr(BASE + TMR_CTRL, 32'b001);              // edge E
      rd(BASE + TMR_COUNT + 32'd2, d);           // byte lane bits ignored
      checks++;
      if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_pre got %h want ffffffff", d); end
      @(negedge CLK);
      rd(BASE + TMR_COUNT, d);
      rd(BASE + TMR_STATUS, m);
      checks++;
      if (d !== 32'd0 || m !== 32'd0) begin
         failures++; $display("FAIL wrap count=%h match=%0d want 0 0", d, m);
      end
      @(negedge CLK);
      rd(BASE + TMR_COUNT, d);
      checks++;
      if (d !== 32'd1) begin failures++; $display("FAIL wrap_next got %h want 1", d); end
   endtask

   task automatic test_midrun_reset();
      logic [31:0] d;
      do_reset();
      wr(BASE + TMR_PRESCALE, 32'd3);
      wr(BASE + TMR_COMPARE, 32'd100);
      wr(BASE + TMR_CTRL, 32'b011);              // edge E
      repeat (10) @(negedge CLK);                // ticks at E+4, E+8
      rd(BASE + TMR_COUNT, d);
      checks++;
      if (d !== 32'd2) begin failures++; $display("FAIL midrun_pre got %0d want 2", d); end
      RST = 1'b1;
      IOBUS_ADDR = BASE + TMR_CTRL;
      IOBUS_OUT = 32'b111;
      IOBUS_WR = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      IOBUS_WR = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rd(BASE + 32'(i * 4), d);
         checks++;
         if (d !== 32'd0) begin
            failures++; $display("FAIL midrun_reg off=%0h got %h want 0", i * 4, d);
         end
      end
      checks++;
      if (INTR !== 1'b0) begin failures++; $display("FAIL midrun_intr got %b want 0", INTR); end
      repeat (8) @(negedge CLK);
      rd(BASE + TMR_COUNT, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL midrun_frozen got %0d want 0", d); end
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_periodic();
      test_oneshot();
      test_wrap();
      test_midrun_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
